// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. Accepts the
//   M-extension funct3 directly and runs a radix-2 shift-add multiplier or a
//   restoring divider on operand magnitudes, one bit per cycle. A one-cycle
//   FIX step applies the sign correction and the divide-by-zero override.
//   Latency is XLEN+2 cycles from start to done for every operation.
//
// Parameters
//   XLEN   operand/result width (>= 4)
//   CNT_W  iteration counter width (derived, leave at default)
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   start   in   request; accepted in IDLE or DONE only
//   funct3  in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM 111 REMU
//   a, b    in   rs1 / rs2 operands
//   flush   in   synchronous abort; returns to IDLE, result untouched
//   busy    out  high while in CALC or FIX
//   done    out  one-cycle pulse, result valid
//   result  out  holds its value until the next done
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;         // raw rs1, returned by REM on divide-by-zero
    logic [XLEN-1:0]   r_mag_a;     // multiplicand magnitude
    logic [XLEN-1:0]   r_mag_b;     // divisor magnitude
    logic              r_neg_q;     // product / quotient must be negated
    logic              r_neg_r;     // remainder must be negated (dividend negative)
    logic              r_div0;
    logic [2*XLEN-1:0] r_prod;      // {partial product, remaining multiplier bits}
    logic [XLEN-1:0]   r_quot;      // dividend bits shift out MSB first, quotient bits shift in
    logic [XLEN-1:0]   r_rem;       // settled remainder, always < divisor so XLEN bits suffice
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_signed_a;
    logic            w_signed_b;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;

    assign w_accept   = start && !flush && (r_state == S_IDLE || r_state == S_DONE);

    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
    assign w_signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    assign w_signed_b = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    assign w_neg_a    = w_signed_a && a[XLEN-1];
    assign w_neg_b    = w_signed_b && b[XLEN-1];
    // Negating the most-negative value yields 2^(XLEN-1), which is exact as unsigned.
    assign w_mag_a    = w_neg_a ? (~a + 1'b1) : a;
    assign w_mag_b    = w_neg_b ? (~b + 1'b1) : b;

    // ------------------------------------------------------------------
    // One multiply step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole register right.
    // ------------------------------------------------------------------
    logic [XLEN:0] w_mul_sum;

    assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]}
                     + {1'b0, (r_prod[0] ? r_mag_a : {XLEN{1'b0}})};

    // ------------------------------------------------------------------
    // One restoring-divide step on the XLEN+1-bit partial remainder.
    // The extra MSB of w_diff is the borrow of the trial subtraction.
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN+1:0] w_diff;
    logic            w_fits;

    assign w_rem_sh = {r_rem, r_quot[XLEN-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_mag_b};
    assign w_fits   = !w_diff[XLEN+1];

    // ------------------------------------------------------------------
    // FIX: sign correction, divide-by-zero override, result select
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_sel;

    assign w_prod_fix = r_neg_q ? (~r_prod + 1'b1) : r_prod;
    assign w_quot_fix = r_div0 ? {XLEN{1'b1}} : (r_neg_q ? (~r_quot + 1'b1) : r_quot);
    assign w_rem_fix  = r_div0 ? r_a : (r_neg_r ? (~r_rem + 1'b1) : r_rem);

    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        w_fix_sel = w_prod_fix[XLEN-1:0];
        case (r_op)
            3'b000:                 w_fix_sel = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_sel = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_sel = w_quot_fix;
            default:                w_fix_sel = w_rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state; flush beats everything except reset.
    // ------------------------------------------------------------------
    logic [1:0] w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = start ? S_CALC : S_IDLE;
            S_CALC:         w_state_nxt = (r_cnt == LAST_ITER) ? S_FIX : S_CALC;
            S_FIX:          w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_prod   <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Status flags follow the next state so they line up with it.
            r_busy  <= (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_op    <= funct3;
                r_a     <= a;
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_neg_q <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_neg_a;
                r_div0  <= (b == '0);
                r_prod  <= {{XLEN{1'b0}}, w_mag_b};
                r_quot  <= w_mag_a;
                r_rem   <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_CALC && !flush) begin
                r_cnt  <= r_cnt + 1'b1;
                r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
                if (w_fits) begin
                    r_rem  <= w_diff[XLEN-1:0];
                    r_quot <= {r_quot[XLEN-2:0], 1'b1};
                end else begin
                    r_rem  <= w_rem_sh[XLEN-1:0];
                    r_quot <= {r_quot[XLEN-2:0], 1'b0};
                end
            end else if (r_state == S_FIX && !flush) begin
                r_result <= w_fix_sel;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit (XLEN = 32). Every expected
//   value is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int LAT = 34;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one edge, then scramble the operand inputs so
    // that any failure to latch them shows up in the result.
    task automatic issue(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb);
        start  = 1'b1;
        funct3 = f;
        a      = aa;
        b      = bb;
        step();
        start  = 1'b0;
        funct3 = ~f;
        a      = ~aa;
        b      = ~bb;
    endtask

    // Called in cycle 1 after acceptance; returns with cyc = cycle of done.
    task automatic wait_done(inout int cyc);
        while (!done && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] exp, input string tag);
        int cyc;
        issue(f, aa, bb);
        cyc = 1;
        check({tag, " busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, " latency"}, 32'(cyc), 32'(LAT));
        check({tag, " result"}, result, exp);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [31:0] prior;

        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        a      = '0;
        b      = '0;
        repeat (3) step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        step();

        // Multiply family
        run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
        step();
        check("done pulse ends", 32'(done), 32'd0);
        check("idle not busy", 32'(busy), 32'd0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min");
        // The following ops are issued in the DONE cycle of the previous one.
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max");

        // Divide family
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "DIV -7/2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "REM -7/2");
        run_op(3'b101, 32'd100,       32'd7,        32'd14,        "DIVU 100/7");
        run_op(3'b111, 32'd100,       32'd7,        32'd2,         "REMU 100/7");
        run_op(3'b100, 32'd5,         32'd0,        32'hFFFF_FFFF, "DIV 5/0");
        run_op(3'b110, 32'd5,         32'd0,        32'd5,         "REM 5/0");
        run_op(3'b101, 32'h8000_0000, 32'd0,        32'hFFFF_FFFF, "DIVU min/0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "REM ovf");
        run_op(3'b110, 32'd20,        32'hFFFF_FFF9, 32'd6,         "REM 20/-7");
        step();

        // start pulsed again mid-operation with different operands: ignored.
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        cyc = 1;
        while (cyc < 10) begin
            step();
            cyc++;
        end
        start  = 1'b1;
        funct3 = 3'b101;
        a      = 32'd100;
        b      = 32'd7;
        step();
        cyc++;
        start = 1'b0;
        wait_done(cyc);
        check("restart ignored latency", 32'(cyc), 32'(LAT));
        check("restart ignored result", result, 32'hFFFF_FFEB);

        // start held in the DONE cycle: second op accepted immediately.
        issue(3'b111, 32'd100, 32'd7);
        check("b2b busy after accept", 32'(busy), 32'd1);
        check("b2b done dropped", 32'(done), 32'd0);
        cyc = 1;
        wait_done(cyc);
        check("b2b latency", 32'(cyc), 32'(LAT));
        check("b2b result", result, 32'd2);
        step();
        prior = 32'd2;

        // flush in cycle 15: busy drops, no done, result kept.
        issue(3'b101, 32'd100, 32'd7);
        cyc = 1;
        while (cyc < 15) begin
            step();
            cyc++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            step();
        end
        check("flush no done", 32'(seen), 32'd0);
        check("flush result kept", result, prior);

        // reset in cycle 20: outputs clear, then a fresh op completes.
        issue(3'b000, 32'd3, 32'd5);
        cyc = 1;
        while (cyc < 20) begin
            step();
            cyc++;
        end
        reset = 1'b1;
        step();
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        reset = 1'b0;
        step();
        run_op(3'b111, 32'd100, 32'd7, 32'd2, "REMU after reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
